// File: rtl/jump_pkg.sv
// Shared types and instruction field positions for the jump resolution unit.
package jump_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BASE,
      RESOLVE,
      SHADOW
   } state_t;

   localparam logic [3:0] OPC_JMP_DEF = 4'hF;

   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 12;
   localparam int REG_HI   = 11;
   localparam int REG_LO   = 8;
   localparam int IMM_HI   = 11;
   localparam int IMM_LO   = 2;
   localparam int OFF_HI   = 7;
   localparam int OFF_LO   = 2;
   localparam int TYPE_BIT = 0;

   localparam int IMM_W = IMM_HI - IMM_LO + 1;
   localparam int OFF_W = OFF_HI - OFF_LO + 1;

endpackage

// File: rtl/jump_resolver_if.sv
// Fetch/decode/register-file bundle seen by the jump resolver.
interface jump_resolver_if #(
   parameter int FETCH_W = 4,
   parameter int INSTR_W = 16,
   parameter int ADDR_W  = 16
);
   logic                       flush;
   logic                       fetch_valid;
   logic [ADDR_W-1:0]          fetch_pc;
   logic [FETCH_W*INSTR_W-1:0] fetch_instr;
   logic                       base_valid;
   logic [ADDR_W-1:0]          base_value;
   logic                       base_req_valid;
   logic [3:0]                 base_req_reg;
   logic                       redirect_valid;
   logic [ADDR_W-1:0]          redirect_pc;
   logic                       stall;
   logic [FETCH_W-1:0]         issue_mask;
   logic [FETCH_W*INSTR_W-1:0] issue_instr;

   modport master (
      output flush, fetch_valid, fetch_pc, fetch_instr, base_valid, base_value,
      input  base_req_valid, base_req_reg, redirect_valid, redirect_pc, stall,
             issue_mask, issue_instr
   );

   modport slave (
      input  flush, fetch_valid, fetch_pc, fetch_instr, base_valid, base_value,
      output base_req_valid, base_req_reg, redirect_valid, redirect_pc, stall,
             issue_mask, issue_instr
   );

endinterface

// File: rtl/jump_first_find.sv
// Per-slot jump decode and priority select of the lowest-index jump in a fetch group.
module jump_first_find
   import jump_pkg::*;
#(
   parameter int         FETCH_W = 4,
   parameter int         INSTR_W = 16,
   parameter int         ADDR_W  = 16,
   parameter logic [3:0] OPC_JMP = OPC_JMP_DEF,
   parameter int         KW      = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
   input  logic [ADDR_W-1:0]          i_pc,
   input  logic [FETCH_W*INSTR_W-1:0] i_instr,
   output logic                       o_found,
   output logic [KW-1:0]              o_k,
   output logic                       o_is_reg,
   output logic [ADDR_W-1:0]          o_imm_target,
   output logic [3:0]                 o_reg,
   output logic [ADDR_W-1:0]          o_off
);

   logic [INSTR_W-1:0] w_slot;

   // Scan from the top slot down so the lowest-index jump is the last one written.
   always_comb begin
      o_found      = 1'b0;
      o_k          = '0;
      o_is_reg     = 1'b0;
      o_imm_target = '0;
      o_reg        = '0;
      o_off        = '0;
      w_slot       = '0;
      for (int i = FETCH_W - 1; i >= 0; i--) begin
         w_slot = i_instr[i*INSTR_W +: INSTR_W];
         if (w_slot[OPC_HI:OPC_LO] == OPC_JMP) begin
            o_found      = 1'b1;
            o_k          = KW'(i);
            o_is_reg     = w_slot[TYPE_BIT];
            o_imm_target = i_pc + ADDR_W'(i + 1)
                         + {{(ADDR_W-IMM_W){w_slot[IMM_HI]}}, w_slot[IMM_HI:IMM_LO]};
            o_reg        = w_slot[REG_HI:REG_LO];
            o_off        = {{(ADDR_W-OFF_W){w_slot[OFF_HI]}}, w_slot[OFF_HI:OFF_LO]};
         end
      end
   end

endmodule

// File: rtl/jump_resolver.sv
// Front-end jump resolver: immediate jumps redirect in the fetch cycle, register
// jumps fetch their base through a request/return handshake before redirecting.
module jump_resolver
   import jump_pkg::*;
#(
   parameter int         FETCH_W    = 4,
   parameter int         INSTR_W    = 16,
   parameter int         ADDR_W     = 16,
   parameter logic [3:0] OPC_JMP    = OPC_JMP_DEF,
   parameter int         SHADOW_CYC = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   jump_resolver_if.slave  bus
);

   localparam int         KW        = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
   localparam state_t     POST_JUMP = (SHADOW_CYC == 0) ? IDLE : SHADOW;
   localparam logic [1:0] CNT_INIT  = 2'(SHADOW_CYC);

   state_t              r_state;
   logic [1:0]          r_cnt;
   logic [ADDR_W-1:0]   r_off;
   logic [ADDR_W-1:0]   r_base;

   state_t              w_nstate;
   logic [1:0]          w_ncnt;
   logic [ADDR_W-1:0]   w_noff;
   logic [ADDR_W-1:0]   w_nbase;
   logic                w_found;
   logic [KW-1:0]       w_k;
   logic                w_is_reg;
   logic [ADDR_W-1:0]   w_imm_target;
   logic [3:0]          w_reg;
   logic [ADDR_W-1:0]   w_off;
   logic [FETCH_W-1:0]  w_keep;

   jump_first_find #(
      .FETCH_W (FETCH_W),
      .INSTR_W (INSTR_W),
      .ADDR_W  (ADDR_W),
      .OPC_JMP (OPC_JMP),
      .KW      (KW)
   ) u_find (
      .i_pc         (bus.fetch_pc),
      .i_instr      (bus.fetch_instr),
      .o_found      (w_found),
      .o_k          (w_k),
      .o_is_reg     (w_is_reg),
      .o_imm_target (w_imm_target),
      .o_reg        (w_reg),
      .o_off        (w_off)
   );

   always_comb begin
      w_keep = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         w_keep[i] = (i <= int'(w_k));
      end
   end

   // Outputs are decoded from state in the same cycle; reset and flush force them quiet.
   always_comb begin
      bus.base_req_valid = 1'b0;
      bus.base_req_reg   = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.stall          = 1'b0;
      bus.issue_mask     = '0;
      w_nstate           = r_state;
      w_ncnt             = r_cnt;
      w_noff             = r_off;
      w_nbase            = r_base;
      if (!rst_n) begin
         w_nstate = IDLE;
      end else if (bus.flush) begin
         w_nstate = IDLE;
         w_ncnt   = '0;
         w_noff   = '0;
         w_nbase  = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.fetch_valid) begin
                  if (!w_found) begin
                     bus.issue_mask = '1;
                  end else if (!w_is_reg) begin
                     bus.issue_mask     = w_keep;
                     bus.redirect_valid = 1'b1;
                     bus.redirect_pc    = w_imm_target;
                     w_nstate           = POST_JUMP;
                     w_ncnt             = CNT_INIT;
                  end else begin
                     bus.issue_mask     = w_keep;
                     bus.base_req_valid = 1'b1;
                     bus.base_req_reg   = w_reg;
                     w_noff             = w_off;
                     w_nstate           = WAIT_BASE;
                  end
               end
            end
            WAIT_BASE: begin
               bus.stall = 1'b1;
               if (bus.base_valid) begin
                  w_nbase  = bus.base_value;
                  w_nstate = RESOLVE;
               end
            end
            RESOLVE: begin
               bus.redirect_valid = 1'b1;
               bus.redirect_pc    = r_base + r_off;
               w_nstate           = POST_JUMP;
               w_ncnt             = CNT_INIT;
            end
            SHADOW: begin
               if (r_cnt <= 2'd1) begin
                  w_nstate = IDLE;
                  w_ncnt   = '0;
               end else begin
                  w_ncnt = r_cnt - 2'd1;
               end
            end
            default: w_nstate = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.issue_instr = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (bus.issue_mask[i]) begin
            bus.issue_instr[i*INSTR_W +: INSTR_W] = bus.fetch_instr[i*INSTR_W +: INSTR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_off   <= '0;
         r_base  <= '0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_off   <= w_noff;
         r_base  <= w_nbase;
      end
   end

endmodule

// File: tb/tb_jump_resolver.sv
// Self-checking bench for jump_resolver: directed corner cases, then random fetch
// groups compared against a slot-scanning reference model.
module tb_jump_resolver;

   localparam int FETCH_W    = 4;
   localparam int INSTR_W    = 16;
   localparam int ADDR_W     = 16;
   localparam int SHADOW_CYC = 1;

   logic clk;
   logic rst_n;
   int   nVectors;
   int   nMiscompares;

   jump_resolver_if #(.FETCH_W(FETCH_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

   jump_resolver #(
      .FETCH_W    (FETCH_W),
      .INSTR_W    (INSTR_W),
      .ADDR_W     (ADDR_W),
      .OPC_JMP    (4'hF),
      .SHADOW_CYC (SHADOW_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs and move to the falling edge for checking.
   task automatic applyStimulus(input logic fv, input logic [15:0] pc, input logic [63:0] grp,
                                input logic bv, input logic [15:0] bval, input logic fl);
      bus.fetch_valid = fv;
      bus.fetch_pc    = pc;
      bus.fetch_instr = grp;
      bus.base_valid  = bv;
      bus.base_value  = bval;
      bus.flush       = fl;
      @(negedge clk);
   endtask

   // Reference decode: first slot whose opcode is 0xF, with targets from plain integer math.
   task automatic refDecode(input logic [15:0] pc, input logic [63:0] grp,
                            output bit found, output int k, output bit isReg,
                            output int target, output int regIdx, output int off);
      logic [15:0] s;
      int imm;
      found = 0; k = 0; isReg = 0; target = 0; regIdx = 0; off = 0;
      for (int j = FETCH_W - 1; j >= 0; j--) begin
         s = grp[j*16 +: 16];
         if (s[15:12] == 4'hF) begin
            found  = 1;
            k      = j;
            isReg  = s[0];
            imm    = int'(s[11:2]);
            if (imm >= 512) imm -= 1024;
            target = (int'(pc) + j + 1 + imm) & 32'hFFFF;
            regIdx = int'(s[11:8]);
            off    = int'(s[7:2]);
            if (off >= 32) off -= 64;
         end
      end
   endtask

   function automatic logic [63:0] maskedGroup(input logic [63:0] grp, input int keepCount);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < keepCount; j++) r[j*16 +: 16] = grp[j*16 +: 16];
      return r;
   endfunction

   function automatic logic [63:0] randomGroup(input int jumpOdds);
      logic [63:0] g;
      logic [15:0] s;
      for (int j = 0; j < FETCH_W; j++) begin
         s = 16'($urandom);
         if ($urandom_range(0, jumpOdds) == 0) s[15:12] = 4'hF;
         else if (s[15:12] == 4'hF) s[15:12] = 4'hE;
         g[j*16 +: 16] = s;
      end
      return g;
   endfunction

   task automatic checkShadow(input string tag);
      for (int c = 0; c < SHADOW_CYC; c++) begin
         applyStimulus(1'b1, 16'($urandom), randomGroup(1), 1'($urandom), 16'($urandom), 1'b0);
         checkOutput({tag, "_shadow_mask"}, 64'(bus.issue_mask), 64'h0);
         checkOutput({tag, "_shadow_redir"}, 64'(bus.redirect_valid), 64'h0);
         checkOutput({tag, "_shadow_req"}, 64'(bus.base_req_valid), 64'h0);
         tick();
      end
   endtask

   // One full transaction from the IDLE fetch cycle back to IDLE, checked against refDecode.
   task automatic runGroup(input logic [15:0] pc, input logic [63:0] grp, input int baseLat);
      bit found, isReg;
      int k, target, regIdx, off;
      logic [15:0] base;
      refDecode(pc, grp, found, k, isReg, target, regIdx, off);
      applyStimulus(1'b1, pc, grp, 1'($urandom), 16'($urandom), 1'b0);
      if (!found) begin
         checkOutput("plain_mask", 64'(bus.issue_mask), 64'hF);
         checkOutput("plain_redir", 64'(bus.redirect_valid), 64'h0);
         checkOutput("plain_instr", 64'(bus.issue_instr), grp);
         tick();
      end else if (!isReg) begin
         checkOutput("imm_redir", 64'(bus.redirect_valid), 64'h1);
         checkOutput("imm_pc", 64'(bus.redirect_pc), 64'(target));
         checkOutput("imm_mask", 64'(bus.issue_mask), 64'((1 << (k + 1)) - 1));
         checkOutput("imm_instr", 64'(bus.issue_instr), maskedGroup(grp, k + 1));
         checkOutput("imm_req", 64'(bus.base_req_valid), 64'h0);
         tick();
         checkShadow("imm");
      end else begin
         checkOutput("reg_req", 64'(bus.base_req_valid), 64'h1);
         checkOutput("reg_idx", 64'(bus.base_req_reg), 64'(regIdx));
         checkOutput("reg_mask", 64'(bus.issue_mask), 64'((1 << (k + 1)) - 1));
         checkOutput("reg_redir", 64'(bus.redirect_valid), 64'h0);
         tick();
         for (int c = 0; c < baseLat; c++) begin
            applyStimulus(1'b1, 16'($urandom), randomGroup(1), 1'b0, 16'($urandom), 1'b0);
            checkOutput("wait_stall", 64'(bus.stall), 64'h1);
            checkOutput("wait_mask", 64'(bus.issue_mask), 64'h0);
            tick();
         end
         base = 16'($urandom);
         applyStimulus(1'b1, 16'($urandom), randomGroup(1), 1'b1, base, 1'b0);
         checkOutput("ret_stall", 64'(bus.stall), 64'h1);
         tick();
         applyStimulus(1'b1, 16'($urandom), randomGroup(1), 1'b0, 16'($urandom), 1'b0);
         checkOutput("res_redir", 64'(bus.redirect_valid), 64'h1);
         checkOutput("res_pc", 64'(bus.redirect_pc), 64'((int'(base) + off) & 32'hFFFF));
         checkOutput("res_stall", 64'(bus.stall), 64'h0);
         checkOutput("res_mask", 64'(bus.issue_mask), 64'h0);
         tick();
         checkShadow("reg");
      end
   endtask

   initial begin
      nVectors     = 0;
      nMiscompares = 0;
      rst_n        = 1'b0;
      bus.flush       = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = 16'h0100;
      bus.fetch_instr = 64'h1111_2222_3333_4444;
      bus.base_valid  = 1'b0;
      bus.base_value  = '0;
      #12;
      $display("[TB] reset state");
      checkOutput("rst_mask", 64'(bus.issue_mask), 64'h0);
      checkOutput("rst_redir", 64'(bus.redirect_valid), 64'h0);
      checkOutput("rst_pc", 64'(bus.redirect_pc), 64'h0);
      checkOutput("rst_stall", 64'(bus.stall), 64'h0);
      checkOutput("rst_req", 64'(bus.base_req_valid), 64'h0);
      tick();
      rst_n = 1'b1;

      $display("[TB] immediate jump");
      applyStimulus(1'b1, 16'h0100, {16'h1234, 16'h5678, 16'hF014, 16'h0001}, 1'b0, 16'h0, 1'b0);
      checkOutput("d_imm_redir", 64'(bus.redirect_valid), 64'h1);
      checkOutput("d_imm_pc", 64'(bus.redirect_pc), 64'h0107);
      checkOutput("d_imm_mask", 64'(bus.issue_mask), 64'h3);
      tick();
      applyStimulus(1'b1, 16'h0104, 64'h1111_2222_3333_4444, 1'b0, 16'h0, 1'b0);
      checkOutput("d_shadow_mask", 64'(bus.issue_mask), 64'h0);
      tick();
      applyStimulus(1'b1, 16'h0107, 64'h1111_2222_3333_4444, 1'b0, 16'h0, 1'b0);
      checkOutput("d_back_idle", 64'(bus.issue_mask), 64'hF);
      tick();

      $display("[TB] register jump");
      applyStimulus(1'b1, 16'h0200, {16'h1234, 16'hF3F9, 16'h1234, 16'h1234}, 1'b0, 16'h0, 1'b0);
      checkOutput("d_reg_req", 64'(bus.base_req_valid), 64'h1);
      checkOutput("d_reg_idx", 64'(bus.base_req_reg), 64'h3);
      checkOutput("d_reg_mask", 64'(bus.issue_mask), 64'h7);
      tick();
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 16'h0204, 64'h0, 1'b0, 16'h0, 1'b0);
         checkOutput("d_wait_stall", 64'(bus.stall), 64'h1);
         tick();
      end
      applyStimulus(1'b1, 16'h0204, 64'h0, 1'b1, 16'h2000, 1'b0);
      checkOutput("d_ret_stall", 64'(bus.stall), 64'h1);
      tick();
      applyStimulus(1'b1, 16'h0204, 64'h0, 1'b0, 16'h0, 1'b0);
      checkOutput("d_res_pc", 64'(bus.redirect_pc), 64'h1FFE);
      checkOutput("d_res_stall", 64'(bus.stall), 64'h0);
      tick();
      tick();

      $display("[TB] two jumps, pc wrap");
      applyStimulus(1'b1, 16'h0300, {16'hF3F9, 16'h1234, 16'h1234, 16'hF008}, 1'b0, 16'h0, 1'b0);
      checkOutput("d_two_pc", 64'(bus.redirect_pc), 64'h0303);
      checkOutput("d_two_mask", 64'(bus.issue_mask), 64'h1);
      checkOutput("d_two_req", 64'(bus.base_req_valid), 64'h0);
      tick();
      tick();
      applyStimulus(1'b1, 16'hFFFE, {16'h1234, 16'h1234, 16'h1234, 16'hF00C}, 1'b0, 16'h0, 1'b0);
      checkOutput("d_wrap_pc", 64'(bus.redirect_pc), 64'h0002);
      tick();
      tick();

      $display("[TB] flush in WAIT_BASE");
      applyStimulus(1'b1, 16'h0400, {16'h1234, 16'h1234, 16'h1234, 16'hF5F9}, 1'b0, 16'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0404, 64'h0, 1'b1, 16'h3000, 1'b1);
      checkOutput("d_fl_redir", 64'(bus.redirect_valid), 64'h0);
      checkOutput("d_fl_stall", 64'(bus.stall), 64'h0);
      checkOutput("d_fl_mask", 64'(bus.issue_mask), 64'h0);
      tick();
      applyStimulus(1'b1, 16'h0500, 64'h1111_2222_3333_4444, 1'b0, 16'h0, 1'b0);
      checkOutput("d_fl_idle_mask", 64'(bus.issue_mask), 64'hF);
      checkOutput("d_fl_idle_stall", 64'(bus.stall), 64'h0);
      checkOutput("d_fl_idle_redir", 64'(bus.redirect_valid), 64'h0);
      tick();

      $display("[TB] reset mid-RESOLVE");
      applyStimulus(1'b1, 16'h0600, {16'h1234, 16'h1234, 16'h1234, 16'hF5F9}, 1'b0, 16'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0604, 64'h0, 1'b1, 16'h4000, 1'b0);
      tick();
      bus.base_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("d_rr_redir", 64'(bus.redirect_valid), 64'h0);
      checkOutput("d_rr_pc", 64'(bus.redirect_pc), 64'h0);
      checkOutput("d_rr_mask", 64'(bus.issue_mask), 64'h0);
      checkOutput("d_rr_stall", 64'(bus.stall), 64'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'h0100, {16'h1234, 16'h5678, 16'hF014, 16'h0001}, 1'b0, 16'h0, 1'b0);
      checkOutput("d_rr_resume_pc", 64'(bus.redirect_pc), 64'h0107);
      checkOutput("d_rr_resume_mask", 64'(bus.issue_mask), 64'h3);
      tick();
      tick();

      $display("[TB] random groups");
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            applyStimulus(1'b0, 16'($urandom), randomGroup(1), 1'($urandom), 16'($urandom), 1'b0);
            checkOutput("r_novalid_mask", 64'(bus.issue_mask), 64'h0);
            checkOutput("r_novalid_instr", 64'(bus.issue_instr), 64'h0);
            tick();
         end else begin
            runGroup(16'($urandom), randomGroup(4), $urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
